// File: rtl/matmul_job_sequencer_if.sv
// rtl/matmul_job_sequencer_if.sv - signal bundle between matmul_job_sequencer and its host, engine and result consumer
//
// Signal groups:
//   job_*        descriptor handshake and the four 3-bit matrix dimensions (x = columns, y = rows)
//   abort        synchronous abort of the job in flight
//   src_*        8-bit operand stream, M1 row-major then M2 row-major
//   eng_*        control, dimension and operand outputs to the matrix engine; eng_ready back from it
//   res_take     one result beat consumed downstream
//   busy/done/err job status
//
// modport master is the sequencer's view; modport slave is the view of everything around it.
interface matmul_job_sequencer_if;
    logic       job_valid;
    logic       job_ready;
    logic [2:0] job_m1x;
    logic [2:0] job_m1y;
    logic [2:0] job_m2x;
    logic [2:0] job_m2y;
    logic       abort;
    logic       src_valid;
    logic       src_ready;
    logic [7:0] src_data;
    logic [2:0] eng_M1Xin;
    logic [2:0] eng_M1Yin;
    logic [2:0] eng_M2Xin;
    logic [2:0] eng_M2Yin;
    logic       eng_program_dim;
    logic       eng_program_val;
    logic [7:0] eng_data_in;
    logic       eng_start;
    logic       eng_ready;
    logic       eng_result_read_ready;
    logic       res_take;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        input  job_valid, job_m1x, job_m1y, job_m2x, job_m2y, abort,
        input  src_valid, src_data, eng_ready, res_take,
        output job_ready, src_ready,
        output eng_M1Xin, eng_M1Yin, eng_M2Xin, eng_M2Yin,
        output eng_program_dim, eng_program_val, eng_data_in,
        output eng_start, eng_result_read_ready,
        output busy, done, err
    );

    modport slave (
        output job_valid, job_m1x, job_m1y, job_m2x, job_m2y, abort,
        output src_valid, src_data, eng_ready, res_take,
        input  job_ready, src_ready,
        input  eng_M1Xin, eng_M1Yin, eng_M2Xin, eng_M2Yin,
        input  eng_program_dim, eng_program_val, eng_data_in,
        input  eng_start, eng_result_read_ready,
        input  busy, done, err
    );
endinterface

// File: rtl/matmul_job_sequencer.sv
// rtl/matmul_job_sequencer.sv - sequences one matrix-multiply job through the matrix engine
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset; abandons any job without done/err
//   bus    matmul_job_sequencer_if.master (job descriptor, operand stream,
//          engine control, result-take strobe, busy/done/err status)
//
// Flow: IDLE -> DIM -> LOAD -> START -> WAIT -> READ -> DONE -> IDLE.
// abort (any non-IDLE state) or a WAIT timeout returns straight to IDLE.
module matmul_job_sequencer #(
    parameter int DIM_CYCLES = 2,
    parameter int TIMEOUT    = 4096
) (
    input  logic                          clk,
    input  logic                          rst_n,
    matmul_job_sequencer_if.master        bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DIM   = 3'd1,
        S_LOAD  = 3'd2,
        S_START = 3'd3,
        S_WAIT  = 3'd4,
        S_READ  = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t      state;
    state_t      next_state;

    // Latched dimensions double as the registered eng_M* outputs.
    logic [2:0]  m1x_q;
    logic [2:0]  m1y_q;
    logic [2:0]  m2x_q;
    logic [2:0]  m2y_q;
    logic [7:0]  data_q;
    logic        pval_q;
    logic        err_q;

    logic [3:0]  dim_cnt;
    logic [6:0]  beat_cnt;
    logic [15:0] tmo_cnt;
    logic [5:0]  take_cnt;

    logic        job_legal;
    logic        job_fire;
    logic        src_fire;
    logic        leaving;
    logic [5:0]  m1_size;
    logic [5:0]  m2_size;
    logic [6:0]  beats_total;
    logic [5:0]  res_total;
    logic        dim_last;
    logic        beat_last;
    logic        tmo_last;
    logic        take_last;

    assign job_legal = (bus.job_m1x != 3'd0) && (bus.job_m1y != 3'd0) &&
                       (bus.job_m2x != 3'd0) && (bus.job_m2y != 3'd0) &&
                       (bus.job_m1x == bus.job_m2y);

    // job_ready is exactly "state is IDLE", so the accept condition needs no extra term.
    assign job_fire  = (state == S_IDLE) && bus.job_valid;

    // src_ready is high for the whole of LOAD: the state is left on the last beat,
    // so there is never a LOAD cycle without a beat remaining.
    assign src_fire  = (state == S_LOAD) && bus.src_valid;

    assign m1_size     = {3'd0, m1x_q} * {3'd0, m1y_q};
    assign m2_size     = {3'd0, m2x_q} * {3'd0, m2y_q};
    assign beats_total = {1'b0, m1_size} + {1'b0, m2_size};
    assign res_total   = {3'd0, m1y_q} * {3'd0, m2x_q};

    assign dim_last  = (dim_cnt == 4'(DIM_CYCLES - 1));
    assign beat_last = (beat_cnt == beats_total - 7'd1);
    assign tmo_last  = (tmo_cnt == 16'(TIMEOUT - 1));
    assign take_last = (take_cnt == res_total - 6'd1);

    // Any return to IDLE from a job clears the engine-facing registers.
    assign leaving   = (state != S_IDLE) && (next_state == S_IDLE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; abort is checked first so it beats every other event.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (job_fire && job_legal) begin
                    next_state = S_DIM;
                end
            end
            S_DIM: begin
                if (bus.abort) begin
                    next_state = S_IDLE;
                end else if (dim_last) begin
                    next_state = S_LOAD;
                end
            end
            S_LOAD: begin
                if (bus.abort) begin
                    next_state = S_IDLE;
                end else if (src_fire && beat_last) begin
                    next_state = S_START;
                end
            end
            S_START: begin
                if (bus.abort) begin
                    next_state = S_IDLE;
                end else begin
                    next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                // eng_ready is tested before the timeout so a same-cycle ready still completes.
                if (bus.abort) begin
                    next_state = S_IDLE;
                end else if (bus.eng_ready) begin
                    next_state = S_READ;
                end else if (tmo_last) begin
                    next_state = S_IDLE;
                end
            end
            S_READ: begin
                if (bus.abort) begin
                    next_state = S_IDLE;
                end else if (bus.res_take && take_last) begin
                    next_state = S_DONE;
                end
            end
            S_DONE: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Output logic decoded from the state
    always_comb begin
        bus.job_ready             = 1'b0;
        bus.src_ready             = 1'b0;
        bus.eng_program_dim       = 1'b0;
        bus.eng_start             = 1'b0;
        bus.eng_result_read_ready = 1'b0;
        bus.busy                  = 1'b1;
        bus.done                  = 1'b0;
        case (state)
            S_IDLE: begin
                bus.job_ready = 1'b1;
                bus.busy      = 1'b0;
            end
            S_DIM: begin
                bus.eng_program_dim = 1'b1;
            end
            S_LOAD: begin
                bus.src_ready = 1'b1;
            end
            S_START, S_WAIT: begin
                bus.eng_start = 1'b1;
            end
            S_READ: begin
                bus.eng_start             = 1'b1;
                bus.eng_result_read_ready = 1'b1;
            end
            S_DONE: begin
                bus.done = 1'b1;
            end
            default: begin
                bus.busy = 1'b1;
            end
        endcase
    end

    assign bus.eng_M1Xin       = m1x_q;
    assign bus.eng_M1Yin       = m1y_q;
    assign bus.eng_M2Xin       = m2x_q;
    assign bus.eng_M2Yin       = m2y_q;
    assign bus.eng_data_in     = data_q;
    assign bus.eng_program_val = pval_q;
    assign bus.err             = err_q;

    // Per-state counters; each is held at zero outside its own state so it
    // starts from zero on every entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dim_cnt  <= '0;
            beat_cnt <= '0;
            tmo_cnt  <= '0;
            take_cnt <= '0;
        end else begin
            dim_cnt <= (state == S_DIM) ? dim_cnt + 4'd1 : 4'd0;
            tmo_cnt <= (state == S_WAIT) ? tmo_cnt + 16'd1 : 16'd0;

            if (state != S_LOAD) begin
                beat_cnt <= '0;
            end else if (src_fire) begin
                beat_cnt <= beat_cnt + 7'd1;
            end

            if (state != S_READ) begin
                take_cnt <= '0;
            end else if (bus.res_take) begin
                take_cnt <= take_cnt + 6'd1;
            end
        end
    end

    // Dimension, operand and pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m1x_q  <= '0;
            m1y_q  <= '0;
            m2x_q  <= '0;
            m2y_q  <= '0;
            data_q <= '0;
            pval_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            if (job_fire && job_legal) begin
                m1x_q <= bus.job_m1x;
                m1y_q <= bus.job_m1y;
                m2x_q <= bus.job_m2x;
                m2y_q <= bus.job_m2y;
            end else if (leaving) begin
                m1x_q <= '0;
                m1y_q <= '0;
                m2x_q <= '0;
                m2y_q <= '0;
            end

            // data_q only changes on a handshake, so it holds across src_valid gaps.
            if (leaving) begin
                data_q <= '0;
            end else if (src_fire) begin
                data_q <= bus.src_data;
            end

            // A beat that coincides with abort is dropped rather than presented.
            pval_q <= src_fire && !bus.abort;

            err_q  <= (job_fire && !job_legal) ||
                      ((state == S_WAIT) && !bus.abort && !bus.eng_ready && tmo_last);
        end
    end

endmodule

// File: doc/matmul_job_sequencer.md
Name: matmul_job_sequencer

Overview:
- Controller that sequences one matrix-multiply job through the `matrix` engine.
- Accepts a job descriptor holding the two matrix dimensions and checks it.
- Drives the engine's dimension-programming and value-programming phases from an 8-bit source stream, starts the multiply, and waits for the engine's `ready`.
- Opens the result-read window and counts result beats out to a downstream consumer.
- Sits between the host/DMA side and the `matrix` datapath. It is the only driver of the engine's control inputs.

Parameters:
- DIM_CYCLES, 2, number of cycles `program_dim` is held high (range 1..15).
- TIMEOUT, 4096, maximum cycles in WAIT for `eng_ready` before an error is raised (range 1..65535).

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- job_valid  in  1  job descriptor valid.
- job_ready  out  1  sequencer can accept a job.
- job_m1x, job_m1y, job_m2x, job_m2y  in  3 each  matrix dimensions; x = columns, y = rows.
- abort  in  1  synchronous abort of the current job.
- src_valid  in  1  operand byte valid.
- src_ready  out  1  operand byte accepted.
- src_data  in  8  operand byte; M1 row-major first, then M2 row-major.
- eng_M1Xin, eng_M1Yin, eng_M2Xin, eng_M2Yin  out  3 each  dimensions to the engine.
- eng_program_dim  out  1  dimension-programming strobe.
- eng_program_val  out  1  data_in valid strobe.
- eng_data_in  out  8  operand byte to the engine.
- eng_start  out  1  multiply start (level).
- eng_ready  in  1  engine finished.
- eng_result_read_ready  out  1  result-read window open.
- res_take  in  1  downstream consumed one result beat.
- busy  out  1  job in progress.
- done  out  1  one-cycle pulse: job complete.
- err  out  1  one-cycle pulse: descriptor rejected or timeout.

Behaviour:
- Reset (async, `rst_n`=0): state=IDLE. All outputs 0 except `job_ready`=1. Counters cleared. Dimension registers cleared. Reset mid-job abandons the job without a `done` or `err` pulse.
- States: IDLE, DIM, LOAD, START, WAIT, READ, DONE.
- **IDLE**
  - `job_ready`=1. Accept on `job_valid`&&`job_ready`.
  - Legal descriptor: all four dims nonzero and `job_m1x`==`job_m2y`.
  - Legal: latch the dims; next state DIM.
  - Illegal: `err` pulses the next cycle; stay IDLE; nothing else is driven.
- **Dimension outputs:** `eng_M*` are registered from the latched dims. They stay stable from DIM entry until IDLE is re-entered, then return to 0.
- **DIM:** `eng_program_dim`=1 for exactly DIM_CYCLES cycles, then LOAD.
- **LOAD**
  - N = m1x*m1y + m2x*m2y, computed as a 7-bit value (max 98).
  - `src_ready`=1 while beats remain.
  - Each handshake registers `src_data` onto `eng_data_in` and asserts `eng_program_val` for exactly one cycle, the cycle after the handshake.
  - Back-to-back beats give a continuous `program_val`.
  - A gap in `src_valid` gives `program_val`=0 and `eng_data_in` holds its value.
  - After beat N, `src_ready` drops in the same cycle as the handshake. Next state START.
- **START:** `eng_start` rises. It is held high through START, WAIT and READ. START lasts 1 cycle, then WAIT.
- **WAIT**
  - A 16-bit timeout counter starts at 0.
  - `eng_ready`=1 → READ.
  - Counter reaches TIMEOUT-1 without `eng_ready` → `err` pulse, then IDLE with all engine outputs deasserted.
- **READ**
  - `eng_result_read_ready`=1.
  - R = m1y*m2x (max 49). Count `res_take` cycles.
  - On the R-th take → DONE. `res_take` outside READ is ignored.
- **DONE:** `done`=1 for one cycle. `eng_start` and `eng_result_read_ready` are 0. Next state IDLE.
- **busy** = 1 in every state except IDLE.
- **abort** (sampled in any non-IDLE state)
  - Next cycle: IDLE with all engine outputs 0. No `done`, no `err`.
  - abort has priority over every simultaneous event: last src beat, `eng_ready`, final `res_take`, timeout.
  - abort in IDLE has no effect.
- **Simultaneous `eng_ready` and timeout in the same cycle:** `eng_ready` wins.
- **Back-to-back jobs:** `job_ready` returns to 1 in IDLE the cycle after DONE. Minimum job-to-job gap is 1 idle cycle.

Test Plan:
- Legal job 3x2 (m1x=3,m1y=2) times 2x3 (m2x=2,m2y=3), src streams bytes 1..12 with no gaps, `eng_ready` model raises after 20 cycles, `res_take` held 1 → `program_dim` high 2 cycles; `program_val` high 12 consecutive cycles with `data_in`=1..12 in order; `start` held until READ; exactly 4 results taken; `done` pulses once; `busy` falls the same cycle.
- Illegal job m1x=3, m2y=5 → `err` pulse 1 cycle after acceptance; no `program_dim`; `busy` stays 0. Same check for a zero dimension (m1y=0).
- LOAD with `src_valid` toggling 1,0,0,1,… for a 1x1 times 1x1 job (N=2) → `program_val` pulses exactly twice, each 1 cycle after its handshake; `data_in` stable during the gaps.
- TIMEOUT=16 with `eng_ready` never rising → `err` at cycle 16 of WAIT; `eng_start` drops; IDLE; `job_ready`=1.
- `abort` asserted on the cycle of the final `res_take` (7x7 job, R=49) → no `done`, no `err`; IDLE next cycle. A second legal job then runs cleanly.
- `rst_n` pulsed low mid-LOAD (beat 5 of 12) → all outputs 0 immediately (async), `job_ready`=1 after release, no pulse outputs; a following job completes normally.
